i2c_slave_rx_ctrl: RTL and testbench

I2C slave receive front-end: deserialises SDA on SCL, counts bits, matches the device address, drives ACK, and emits one-byte load strobes for the device-ID, memory-address and data stages. It sits directly upstream of the device-ID latch and the address/data registers of the flash I2C slave. All of those consume `ShiftRegOut` together with the matching `Load*` strobe on the falling SCL edge. START/STOP detection is external; this block receives them as flags.

---
 rtl/i2c_slave_pkg.sv | 28 ++
 rtl/i2c_bit_shifter.sv | 44 ++++
 rtl/i2c_slave_rx_ctrl.sv | 111 +++++++++++
 tb/tb_i2c_slave_rx_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C slave receive path.
package i2c_slave_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StDevId   = 3'd1,
    StAckDev  = 3'd2,
    StAddr    = 3'd3,
    StAckAddr = 3'd4,
    StData    = 3'd5,
    StAckData = 3'd6,
    StIgnore  = 3'd7
  } state_e;

  localparam logic [6:0]  DefaultDevAddr = 7'b1010000;
  localparam int unsigned ByteLen        = 8;

  // The shift register holds the first bus bit in [0], so the address compares reversed.
  function automatic logic addr_match(input logic [7:0] sr, input logic [6:0] addr);
    logic m;
    m = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (sr[i] != addr[6-i]) m = 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/i2c_bit_shifter.sv
// Receive shift register with a bit counter; flags the sample that completes a byte.
module i2c_bit_shifter
  import i2c_slave_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               shift_en_i,
  input  logic               sda_i,
  output logic [ByteLen-1:0] shift_o,
  output logic [ByteLen-1:0] shift_next_o,
  output logic               byte_done_o
);

  localparam int unsigned CntW = $clog2(ByteLen);
  localparam logic [CntW-1:0] LastBit = CntW'(ByteLen - 1);

  logic [ByteLen-1:0] sr_q, sr_d;
  logic [CntW-1:0]    cnt_q, cnt_d;

  assign shift_next_o = {sda_i, sr_q[ByteLen-1:1]};
  assign shift_o      = sr_q;
  assign byte_done_o  = shift_en_i & (cnt_q == LastBit);

  // Counter is held at zero whenever not shifting, so every byte entry starts clean.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = '0;
    if (shift_en_i) begin
      sr_d  = shift_next_o;
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/i2c_slave_rx_ctrl.sv
// I2C slave receive controller: address match, ACK drive and per-byte load strobes.
module i2c_slave_rx_ctrl
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DefaultDevAddr
) (
  input  logic       SCL,
  input  logic       RST_n,
  input  logic       SDA_in,
  input  logic       StartDet,
  input  logic       StopDet,
  output logic [7:0] ShiftRegOut,
  output logic       LoadDeviceId,
  output logic       LoadAddr,
  output logic       LoadData,
  output logic       SDA_oe,
  output logic       Busy
);

  state_e     state_q, state_d;
  logic       shift_en, byte_done, id_match;
  logic [7:0] shift_next;
  logic       load_dev_q, load_dev_d;
  logic       load_addr_q, load_addr_d;
  logic       load_data_q, load_data_d;
  logic       sda_oe_q;

  // Start/stop edges carry no data bit; the shifter is frozen and its counter cleared.
  assign shift_en = (state_q inside {StDevId, StAddr, StData}) & ~StartDet & ~StopDet;
  assign id_match = addr_match(shift_next, DEV_ADDR);

  i2c_bit_shifter u_shifter (
    .clk_i        (SCL),
    .rst_ni       (RST_n),
    .shift_en_i   (shift_en),
    .sda_i        (SDA_in),
    .shift_o      (ShiftRegOut),
    .shift_next_o (shift_next),
    .byte_done_o  (byte_done)
  );

  always_comb begin
    state_d     = state_q;
    load_dev_d  = 1'b0;
    load_addr_d = 1'b0;
    load_data_d = 1'b0;
    if (StopDet) begin
      state_d = StIdle;
    end else if (StartDet) begin
      state_d = StDevId;
    end else begin
      unique case (state_q)
        StIdle:    state_d = StIdle;
        StDevId: begin
          if (byte_done) begin
            state_d    = id_match ? StAckDev : StIgnore;
            load_dev_d = id_match;
          end
        end
        // Read transfers belong to the transmit block.
        StAckDev:  state_d = ShiftRegOut[7] ? StIgnore : StAddr;
        StAddr: begin
          if (byte_done) begin
            state_d     = StAckAddr;
            load_addr_d = 1'b1;
          end
        end
        StAckAddr: state_d = StData;
        StData: begin
          if (byte_done) begin
            state_d     = StAckData;
            load_data_d = 1'b1;
          end
        end
        StAckData: state_d = StData;
        StIgnore:  state_d = StIgnore;
        default:   state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge SCL or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= StIdle;
      load_dev_q  <= 1'b0;
      load_addr_q <= 1'b0;
      load_data_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_dev_q  <= load_dev_d;
      load_addr_q <= load_addr_d;
      load_data_q <= load_data_d;
    end
  end

  // ACK is launched on the falling edge so SDA changes only while SCL is low.
  always_ff @(negedge SCL or negedge RST_n) begin
    if (!RST_n) begin
      sda_oe_q <= 1'b0;
    end else begin
      sda_oe_q <= ~StopDet & (state_q inside {StAckDev, StAckAddr, StAckData});
    end
  end

  assign LoadDeviceId = load_dev_q;
  assign LoadAddr     = load_addr_q;
  assign LoadData     = load_data_q;
  assign SDA_oe       = sda_oe_q;
  assign Busy         = (state_q != StIdle) && (state_q != StIgnore);

endmodule

// File: tb/tb_i2c_slave_rx_ctrl.sv
// Randomized bench for i2c_slave_rx_ctrl against a byte-level transaction model.
module tb_i2c_slave_rx_ctrl;
  import i2c_slave_pkg::*;

  localparam logic [6:0] DevAddr = DefaultDevAddr;

  logic       SCL = 1'b0;
  logic       RST_n = 1'b0;
  logic       SDA_in = 1'b1;
  logic       StartDet = 1'b0;
  logic       StopDet = 1'b0;
  logic [7:0] ShiftRegOut;
  logic       LoadDeviceId, LoadAddr, LoadData, SDA_oe, Busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction model: byte position in the frame and whether the slave dropped out.
  int m_pos     = 0;
  bit m_ignored = 1'b1;

  i2c_slave_rx_ctrl #(.DEV_ADDR(DevAddr)) dut (
    .SCL          (SCL),
    .RST_n        (RST_n),
    .SDA_in       (SDA_in),
    .StartDet     (StartDet),
    .StopDet      (StopDet),
    .ShiftRegOut  (ShiftRegOut),
    .LoadDeviceId (LoadDeviceId),
    .LoadAddr     (LoadAddr),
    .LoadData     (LoadData),
    .SDA_oe       (SDA_oe),
    .Busy         (Busy)
  );

  always #5 SCL = ~SCL;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // kind: 0 none, 1 device-ID, 2 memory address, 3 data
  task automatic check_strobes(input string tag, input int kind);
    check_eq({tag, "_ld_dev"},  32'(LoadDeviceId), 32'(kind == 1));
    check_eq({tag, "_ld_addr"}, 32'(LoadAddr),     32'(kind == 2));
    check_eq({tag, "_ld_data"}, 32'(LoadData),     32'(kind == 3));
  endtask

  task automatic model_byte(input logic [7:0] b, output int kind, output bit ack);
    kind = 0;
    ack  = 1'b0;
    if (!m_ignored) begin
      if (m_pos == 0) begin
        if (b[7:1] == DevAddr) begin
          kind      = 1;
          ack       = 1'b1;
          m_ignored = b[0];
        end else begin
          m_ignored = 1'b1;
        end
      end else begin
        kind = (m_pos == 1) ? 2 : 3;
        ack  = 1'b1;
      end
    end
    m_pos++;
  endtask

  task automatic do_start();
    @(negedge SCL);
    #2 StartDet = 1'b1;
    @(posedge SCL);
    #1 StartDet = 1'b0;
    check_eq("start_busy", 32'(Busy), 32'd1);
    check_strobes("start", 0);
    m_pos     = 0;
    m_ignored = 1'b0;
  endtask

  task automatic do_stop();
    @(negedge SCL);
    #2 StopDet = 1'b1;
    @(posedge SCL);
    #1 StopDet = 1'b0;
    check_eq("stop_busy", 32'(Busy), 32'd0);
    check_eq("stop_state", 32'(dut.state_q), 32'(StIdle));
    check_strobes("stop", 0);
    @(negedge SCL);
    #1 check_eq("stop_oe", 32'(SDA_oe), 32'd0);
    m_ignored = 1'b1;
  endtask

  // Drive the first n bits of b, MSB first; no strobe may fire before bit 8.
  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge SCL);
      #1 check_eq("oe_in_byte", 32'(SDA_oe), 32'd0);
      #1 SDA_in = b[3'(7-i)];
      @(posedge SCL);
      #1;
      if (i < 7) check_strobes("mid_byte", 0);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rst_in_ack);
    int kind;
    bit ack;
    send_bits(b, 8);
    model_byte(b, kind, ack);
    check_strobes("byte_end", kind);
    if (kind != 0) check_eq("shift_reg", 32'(ShiftRegOut), 32'(rev8(b)));
    @(negedge SCL);
    #1 check_eq("ack_oe", 32'(SDA_oe), 32'(ack));
    if (rst_in_ack) begin
      #1 RST_n = 1'b0;
      #1 check_eq("rst_oe", 32'(SDA_oe), 32'd0);
      check_eq("rst_state", 32'(dut.state_q), 32'(StIdle));
      check_eq("rst_busy", 32'(Busy), 32'd0);
      check_eq("rst_shift", 32'(ShiftRegOut), 32'd0);
      check_strobes("rst", 0);
      #1 RST_n = 1'b1;
      m_ignored = 1'b1;
    end else begin
      #1 SDA_in = 1'b1;
      @(posedge SCL);
      #1 check_strobes("ack_clk", 0);
      check_eq("ack_busy", 32'(Busy), 32'(!m_ignored));
    end
  endtask

  initial begin
    #2;
    check_eq("reset_shift", 32'(ShiftRegOut), 32'd0);
    check_strobes("reset", 0);
    check_eq("reset_oe", 32'(SDA_oe), 32'd0);
    check_eq("reset_busy", 32'(Busy), 32'd0);
    check_eq("reset_state", 32'(dut.state_q), 32'(StIdle));
    @(negedge SCL);
    #2 RST_n = 1'b1;

    // Write frame with two data bytes.
    do_start();
    send_byte(8'hA0, 1'b0);
    send_byte(8'h3C, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'hAA, 1'b0);
    do_stop();

    // Foreign address: ignored until STOP.
    do_start();
    send_byte(8'hA2, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    do_stop();

    // Read request: ID acknowledged, then hands off.
    do_start();
    send_byte(8'hA1, 1'b0);
    send_byte(8'h3C, 1'b0);
    do_stop();

    // Repeated START part-way through the address byte.
    do_start();
    send_byte(8'hA0, 1'b0);
    send_bits(8'hF0, 4);
    do_start();
    send_byte(8'hA0, 1'b0);
    send_byte(8'h3C, 1'b0);
    do_stop();

    // Asynchronous reset while acknowledging a data byte.
    do_start();
    send_byte(8'hA0, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b1);

    // STOP after five bits of a data byte.
    do_start();
    send_byte(8'hA0, 1'b0);
    send_byte(8'h3C, 1'b0);
    send_bits(8'hC3, 5);
    do_stop();

    for (int f = 0; f < 40; f++) begin
      logic [6:0] id;
      logic       rw;
      int         nb;
      int         ending;
      id     = ($urandom_range(0, 3) != 0) ? DevAddr : 7'($urandom);
      rw     = ($urandom_range(0, 3) == 0);
      nb     = $urandom_range(0, 4);
      ending = $urandom_range(0, 2);
      do_start();
      send_byte({id, rw}, 1'b0);
      for (int k = 0; k < nb; k++) send_byte(8'($urandom), 1'b0);
      if (ending != 0) send_bits(8'($urandom), $urandom_range(1, 7));
      if (ending != 2) do_stop();
    end
    do_stop();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
